// File: rtl/bcd_entry_pad.sv
// Decimal entry pad. Four debounced push-buttons edit a packed-BCD operand.
// The operand is scanned onto a time-multiplexed, active-low 7-segment display.
module bcd_entry_pad #(
    parameter  int DIGITS    = 4,
    parameter  int DB_CYCLES = 1000000,
    parameter  int SCAN_DIV  = 100000,
    parameter  int SAT_MODE  = 0,
    localparam int SEL_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_inc,
    input  logic                btn_dec,
    input  logic                btn_sel,
    input  logic                btn_clr,
    output logic [4*DIGITS-1:0] value,
    output logic [SEL_W-1:0]    sel_digit,
    output logic                changed,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an
);
    localparam int CNT_W  = $clog2(DB_CYCLES);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int B_INC  = 0;
    localparam int B_DEC  = 1;
    localparam int B_SEL  = 2;
    localparam int B_CLR  = 3;

    logic [3:0]       raw;
    logic [3:0]       sync1_q, sync2_q, db_q, db_prev_q, pulse_q;
    logic [CNT_W-1:0] db_cnt_q [4];

    logic [4*DIGITS-1:0] value_d, value_q;
    logic [SEL_W-1:0]    sel_d, sel_q, idx_q;
    logic [SCAN_W-1:0]   scan_cnt_q;
    logic                changed_q, dp_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic [3:0]          cur_digit, shown_digit;

    assign raw = {btn_clr, btn_sel, btn_dec, btn_inc};

    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic up);
        if (up) begin
            if (d >= 4'd9) return (SAT_MODE != 0) ? 4'd9 : 4'd0;
            return d + 4'd1;
        end
        if (d == 4'd0) return (SAT_MODE != 0) ? 4'd0 : 4'd9;
        return d - 4'd1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Input path: synchroniser, debounce (db changes after DB_CYCLES mismatching cycles), rising-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            pulse_q   <= '0;
            for (int b = 0; b < 4; b++) db_cnt_q[b] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep each stage reading the previous cycle's value.
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            pulse_q   <= db_q & ~db_prev_q;
            for (int b = 0; b < 4; b++) begin
                if (sync2_q[b] == db_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == CNT_W'(DB_CYCLES - 1)) begin
                    db_q[b]     <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    assign cur_digit   = value_q[4*sel_q +: 4];
    assign shown_digit = value_q[4*idx_q +: 4];

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        value_d = value_q;
        sel_d   = sel_q;
        if (pulse_q[B_CLR]) begin
            value_d = '0;
        end else begin
            if (pulse_q[B_INC] && !pulse_q[B_DEC])
                value_d[4*sel_q +: 4] = step_digit(cur_digit, 1'b1);
            else if (pulse_q[B_DEC] && !pulse_q[B_INC])
                value_d[4*sel_q +: 4] = step_digit(cur_digit, 1'b0);
            if (pulse_q[B_SEL])
                sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q    <= '0;
            sel_q      <= '0;
            changed_q  <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= ~DIGITS'(1);
            seg_q      <= 7'b0000001;
            dp_q       <= 1'b0;
        end else begin
            value_q   <= value_d;
            sel_q     <= sel_d;
            changed_q <= (value_d != value_q);
            if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                idx_q      <= (idx_q == SEL_W'(DIGITS - 1)) ? '0 : idx_q + SEL_W'(1);
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
            // Display drivers lag the scan index and operand by one cycle, all together.
            an_q  <= ~(DIGITS'(1) << idx_q);
            seg_q <= seg_decode(shown_digit);
            dp_q  <= (idx_q != sel_q);
        end
    end

    assign value     = value_q;
    assign sel_digit = sel_q;
    assign changed   = changed_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
endmodule

// File: tb/tb_bcd_entry_pad.sv
// Bench for bcd_entry_pad: a wrapping and a saturating instance share the same buttons
// and are compared against a digit-level model of the entry pad.
module tb_bcd_entry_pad;
    localparam int DIGITS = 4;
    localparam int DB     = 4;
    localparam int SD     = 2;
    localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                             7'b0000000, 7'b0000100};

    logic clk = 1'b0;
    logic reset;
    logic btn_inc, btn_dec, btn_sel, btn_clr;

    logic [15:0] val_w, val_s;
    logic [1:0]  sel_w, sel_s;
    logic        changed_w, changed_s, dp_w, dp_s;
    logic [6:0]  seg_w, seg_s;
    logic [3:0]  an_w, an_s;

    int checks = 0;
    int failures = 0;
    int chg_w, chg_s;
    logic [15:0] m_val_w, m_val_s;
    int m_sel;
    int prev_idx [2];
    int run_len [2];
    bit seen_change [2];

    always #5 clk = ~clk;

    bcd_entry_pad #(.DIGITS(DIGITS), .DB_CYCLES(DB), .SCAN_DIV(SD), .SAT_MODE(0)) u_wrap (
        .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_sel(btn_sel),
        .btn_clr(btn_clr), .value(val_w), .sel_digit(sel_w), .changed(changed_w),
        .seg(seg_w), .dp(dp_w), .an(an_w));

    bcd_entry_pad #(.DIGITS(DIGITS), .DB_CYCLES(DB), .SCAN_DIV(SD), .SAT_MODE(1)) u_sat (
        .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_sel(btn_sel),
        .btn_clr(btn_clr), .value(val_s), .sel_digit(sel_s), .changed(changed_s),
        .seg(seg_s), .dp(dp_s), .an(an_s));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected operand after one press, from the digit arithmetic rules.
    function automatic logic [15:0] apply(input logic [15:0] v, input logic [3:0] m,
                                          input int sel, input bit sat);
        int d;
        if (m[3]) return 16'h0;
        d = int'(v[4*sel +: 4]);
        if (m[0] && !m[1])      d = sat ? ((d < 9) ? d + 1 : 9) : (d + 1) % 10;
        else if (m[1] && !m[0]) d = sat ? ((d > 0) ? d - 1 : 0) : (d + 9) % 10;
        v[4*sel +: 4] = 4'(d);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (changed_w) chg_w++;
        if (changed_s) chg_s++;
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_clr, btn_sel, btn_dec, btn_inc} = m;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_value_w"}, val_w, 16'h0);
        check({tag, "_value_s"}, val_s, 16'h0);
        check({tag, "_sel"}, sel_w, 0);
        check({tag, "_changed"}, changed_w, 0);
        check({tag, "_an"}, an_w, 4'b1110);
        check({tag, "_seg"}, seg_w, 7'b0000001);
        check({tag, "_dp"}, dp_w, 0);
        check({tag, "_an_s"}, an_s, 4'b1110);
        check({tag, "_seg_s"}, seg_s, 7'b0000001);
    endtask

    // Hold mask m for 'hold' cycles, release, let everything settle, then compare with the model.
    task automatic press(input logic [3:0] m, input int hold, input bit timed);
        logic [15:0] nw, ns;
        nw = (hold >= DB) ? apply(m_val_w, m, m_sel, 1'b0) : m_val_w;
        ns = (hold >= DB) ? apply(m_val_s, m, m_sel, 1'b1) : m_val_s;
        chg_w = 0;
        chg_s = 0;
        set_btns(m);
        for (int i = 1; i <= hold; i++) begin
            step();
            if (timed) begin
                if (i == 7) check("lat_before", val_w, m_val_w);
                if (i == 8) begin
                    check("lat_value", val_w, nw);
                    check("lat_changed", changed_w, 1);
                end
                if (i == 9) check("lat_pulse_len", changed_w, 0);
            end
        end
        set_btns(4'b0000);
        repeat (DB + 8) step();
        if (hold >= DB && !m[3] && m[2]) m_sel = (m_sel + 1) % DIGITS;
        check("changed_w", chg_w, (nw != m_val_w) ? 1 : 0);
        check("changed_s", chg_s, (ns != m_val_s) ? 1 : 0);
        m_val_w = nw;
        m_val_s = ns;
        check("value_w", val_w, m_val_w);
        check("value_s", val_s, m_val_s);
        check("sel_w", sel_w, m_sel);
        check("sel_s", sel_s, m_sel);
    endtask

    task automatic disp_one(input int k, input logic [3:0] an_v, input logic [6:0] seg_v,
                            input logic dp_v, input logic [15:0] mval);
        int idx = -1;
        int lows = 0;
        int dg;
        for (int i = 0; i < DIGITS; i++) if (!an_v[i]) begin idx = i; lows++; end
        check("an_one_low", lows, 1);
        if (lows != 1) return;
        dg = int'(mval[4*idx +: 4]);
        check("seg", seg_v, SEG_TAB[dg]);
        check("dp", dp_v, (idx == m_sel) ? 0 : 1);
        if (idx != prev_idx[k]) begin
            if (prev_idx[k] >= 0) begin
                check("scan_order", idx, (prev_idx[k] + 1) % DIGITS);
                if (seen_change[k]) check("scan_period", run_len[k], SD);
                seen_change[k] = 1'b1;
            end
            prev_idx[k] = idx;
            run_len[k]  = 1;
        end else begin
            run_len[k]++;
        end
    endtask

    task automatic display_check(input int cycles);
        for (int k = 0; k < 2; k++) begin
            prev_idx[k]    = -1;
            run_len[k]     = 0;
            seen_change[k] = 1'b0;
        end
        repeat (cycles) begin
            step();
            disp_one(0, an_w, seg_w, dp_w, m_val_w);
            disp_one(1, an_s, seg_s, dp_s, m_val_s);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] m;
        reset = 1'b1;
        set_btns(4'b0000);
        m_val_w = 16'h0;
        m_val_s = 16'h0;
        m_sel   = 0;
        chg_w   = 0;
        chg_s   = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset("rst");
        reset = 1'b0;

        // Clean press with exact latency, then a bounced press.
        press(4'b0001, 10, 1'b1);
        set_btns(4'b0001); step();
        set_btns(4'b0000); step();
        set_btns(4'b0001); step();
        set_btns(4'b0000); step();
        press(4'b0001, 10, 1'b1);

        // Wrap versus saturation at both ends.
        press(4'b1000, 6, 1'b0);
        press(4'b0010, 6, 1'b0);
        press(4'b1000, 6, 1'b0);
        repeat (12) press(4'b0001, 5, 1'b0);

        // Selection moves, edits go to the selected digit, selection wraps.
        press(4'b1000, 6, 1'b0);
        repeat (2) press(4'b0100, 6, 1'b0);
        repeat (3) press(4'b0001, 6, 1'b0);
        check("sel_is_2", sel_w, 2);
        check("value_0300", val_w, 16'h0300);
        repeat (2) press(4'b0100, 6, 1'b0);

        // Build 1234 with digit 1 selected, then watch the scan.
        press(4'b1000, 6, 1'b0);
        for (int d = 0; d < DIGITS; d++) begin
            repeat (4 - d) press(4'b0001, 5, 1'b0);
            press(4'b0100, 5, 1'b0);
        end
        press(4'b0100, 5, 1'b0);
        check("value_1234", val_w, 16'h1234);
        display_check(8 * SD + 4);

        // Simultaneous inc+dec, then clr+inc.
        press(4'b0011, 6, 1'b0);
        press(4'b1001, 6, 1'b0);
        check("clr_wins", val_w, 16'h0);

        // Random presses, short glitches included, with periodic display checks.
        for (int n = 0; n < 150; n++) begin
            m = 4'($urandom_range(0, 15));
            if (m[3] && $urandom_range(0, 3) != 0) m[3] = 1'b0;
            press(m, int'($urandom_range(1, 8)), 1'b0);
            if (n % 25 == 24) display_check(3 * DIGITS * SD);
        end

        // Reset mid-scan and mid-debounce; the held button then needs the full latency again.
        press(4'b0101, 6, 1'b0);
        display_check(5);
        set_btns(4'b0001);
        repeat (3) step();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset("rst_mid");
        @(negedge clk);
        reset   = 1'b0;
        m_val_w = 16'h0;
        m_val_s = 16'h0;
        m_sel   = 0;
        press(4'b0001, 10, 1'b1);
        display_check(3 * DIGITS * SD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
